// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported fixed-latency memory between the IF and MEM stages.
// MEM wins ties as the older instruction; a starvation counter forces IF through after STARVE_LIMIT MEM wins.
module mem_port_arbiter #(
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_ack_o,
    output logic [31:0] if_rdata_o,
    input  logic        dm_req_i,
    input  logic        dm_we_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_wdata_i,
    output logic        dm_ack_o,
    output logic [31:0] dm_rdata_o,
    output logic        mem_en_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    output logic        stall_if_o,
    output logic        stall_mem_o,
    output logic        busy_o
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        own_q, own_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] dm_rdata_q, dm_rdata_d;
    logic [3:0]  lat_q, lat_d;
    logic [3:0]  starve_q, starve_d;
    logic        take, grant_mem, last;

    assign take      = state_q == IDLE && (if_req_i || dm_req_i);
    assign grant_mem = dm_req_i && !(if_req_i && starve_q == 4'(STARVE_LIMIT));
    assign last      = state_q == WAIT && lat_q == 4'd0;

    // own_q = 1 means the MEM stage owns the current transaction
    always_comb begin
        state_d    = state_q == IDLE  ? (take ? ISSUE : IDLE) :
                     state_q == ISSUE ? WAIT :
                     state_q == WAIT  ? (lat_q == 4'd0 ? RESP : WAIT) : IDLE;
        own_d      = take ? grant_mem : own_q;
        we_d       = take ? grant_mem && dm_we_i : we_q;
        addr_d     = take ? (grant_mem ? dm_addr_i : if_addr_i) : addr_q;
        wdata_d    = take ? (grant_mem ? dm_wdata_i : 32'd0) : wdata_q;
        starve_d   = !take ? starve_q :
                     !(grant_mem && if_req_i) ? 4'd0 :
                     starve_q == 4'hF ? starve_q : starve_q + 4'd1;
        lat_d      = state_q == ISSUE ? 4'(MEM_LATENCY - 1) :
                     state_q == WAIT && lat_q != 4'd0 ? lat_q - 4'd1 : lat_q;
        if_rdata_d = last && !own_q ? mem_rdata_i : if_rdata_q;
        dm_rdata_d = last && own_q && !we_q ? mem_rdata_i : dm_rdata_q;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            own_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            if_rdata_q <= 32'd0;
            dm_rdata_q <= 32'd0;
            lat_q      <= 4'd0;
            starve_q   <= 4'd0;
        end else begin
            state_q    <= state_d;
            own_q      <= own_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            lat_q      <= lat_d;
            starve_q   <= starve_d;
        end
    end

    assign mem_en_o    = state_q == ISSUE;
    assign mem_we_o    = mem_en_o && we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign if_ack_o    = state_q == RESP && !own_q;
    assign dm_ack_o    = state_q == RESP && own_q;
    assign if_rdata_o  = if_rdata_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign stall_if_o  = if_req_i && !if_ack_o;
    assign stall_mem_o = dm_req_i && !dm_ack_o;
    assign busy_o      = state_q != IDLE;
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer and arbiter that shares one single-ported, fixed-latency unified memory between the instruction-fetch (IF) and data-memory (MEM) stages of the 5-stage MIPS pipeline. It accepts held-until-acknowledged requests from both stages and issues one memory access at a time. It returns read data with a one-cycle acknowledge pulse and drives per-stage stall lines that feed PC/IF_ID write-enables and pipeline-register enables. MEM has priority as the older instruction; a starvation limit guarantees IF forward progress.

## Interface
- MEM_LATENCY, 2: cycles from the mem_en cycle to the cycle mem_rdata is valid; legal range 1..15.
- STARVE_LIMIT, 4: consecutive MEM grants while if_req is waiting before IF is forced to win; legal range 1..15.
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  IF read request; held with if_addr until if_ack.
- if_addr  in  32  IF byte address.
- if_ack  out  1  one-cycle pulse; if_rdata valid in that cycle.
- if_rdata  out  32  registered fetch data; holds until the next IF read completes.
- dm_req  in  1  MEM request; held with dm_we/dm_addr/dm_wdata until dm_ack.
- dm_we  in  1  1 = write, 0 = read.
- dm_addr  in  32  MEM byte address.
- dm_wdata  in  32  MEM store data.
- dm_ack  out  1  one-cycle completion pulse.
- dm_rdata  out  32  registered load data; updated only by MEM reads.
- mem_en  out  1  one-cycle access strobe to memory.
- mem_we  out  1  write strobe, valid with mem_en.
- mem_addr  out  32  registered address, valid with mem_en.
- mem_wdata  out  32  registered write data, valid with mem_en.
- mem_rdata  in  32  memory read data, valid MEM_LATENCY cycles after mem_en.
- stall_if  out  1  if_req & ~if_ack.
- stall_mem  out  1  dm_req & ~dm_ack.
- busy  out  1  FSM not in IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if no request, stay. Otherwise grant, latch owner, address, we and wdata, then go to ISSUE.
- Arbitration in IDLE when both requests are pending: MEM wins unless starve_cnt == STARVE_LIMIT, in which case IF wins.
- starve_cnt behaviour:
  - increments (saturating) on a MEM grant while if_req = 1.
  - clears on any IF grant, or on a MEM grant with if_req = 0.
- ISSUE: mem_en = 1 with the latched mem_we, mem_addr and mem_wdata for exactly one cycle. Load lat_cnt = MEM_LATENCY-1 and go to WAIT.
- WAIT: decrement lat_cnt. When lat_cnt == 0, the cycle is the data-valid cycle:
  - capture mem_rdata into if_rdata (IF owner) or dm_rdata (MEM read).
  - nothing is captured for writes.
  - go to RESP.
- RESP: assert the owner's ack for one cycle, then go to IDLE. Requests are not sampled in RESP, so a still-high req of the acked requester is never re-granted.
- Writes follow the same timing as reads.
- If a requester drops req mid-transaction (protocol violation), the transaction still completes and the ack still pulses.
- Addresses are passed through unmodified; no alignment checks.

## Timing
- Request sampled in IDLE at cycle 0:
  - mem_en in cycle 1.
  - data valid in cycle 1+MEM_LATENCY.
  - ack in cycle 2+MEM_LATENCY.
  - IDLE again in cycle 3+MEM_LATENCY.
- With the default MEM_LATENCY = 2: ack at cycle 4; maximum throughput is one access per 5 cycles.
- A requester holding req continuously after its ack is re-sampled in the IDLE cycle following RESP.
- Reset (cycle-synchronous):
  - state = IDLE; starve_cnt = 0; lat_cnt = 0.
  - all outputs 0, including if_rdata and dm_rdata; stall lines follow the inputs.
- Reset mid-transaction: the transaction is aborted and no ack is issued. mem_en is 0 from the next cycle. A write already strobed is not undone.

## Test plan
- Single IF read: MEM_LATENCY = 2, if_req at cycle 0 with if_addr = 0x0040_0000, memory returns 0x2008_0005 in cycle 3 -> mem_en = 1 only in cycle 1 with addr 0x0040_0000; if_ack = 1 only in cycle 4 with if_rdata = 0x2008_0005; stall_if = 1 in cycles 0-3.
- MEM write: dm_we = 1, dm_addr = 0x1001_0004, dm_wdata = 0xDEAD_BEEF -> cycle 1 shows mem_en = 1, mem_we = 1 with that address and data; dm_ack in cycle 4; dm_rdata unchanged.
- Simultaneous requests: if_req and dm_req both high at cycle 0 -> MEM is granted first (dm_ack cycle 4). IF is granted in cycle 5 (IDLE) and if_ack arrives in cycle 9.
- Starvation: STARVE_LIMIT = 2, if_req held high, dm_req re-raised immediately after every ack -> exactly 2 MEM grants, then an IF grant, after which starve_cnt is 0.
- Reset mid-operation: assert reset in cycle 2 of an IF read -> no if_ack is ever seen; busy = 0 and mem_en = 0 from cycle 3. A new request after reset completes normally with ack at latency 2+MEM_LATENCY.
- Latency sweep: MEM_LATENCY = 1 and 15 -> ack arrives at cycle 3 and cycle 17 respectively; the captured data equals mem_rdata in cycle 1+MEM_LATENCY.
